// File: rtl/pipe_stage_chain_pkg.sv
// Shared pipeline constants.
// Holds the default geometry of the stage chain (depth, payload width,
// performance-counter width). The interface, the stage cell and the top
// all take their parameter defaults from here.

package pipe_stage_chain_pkg;

  localparam int NSTAGES_DEFAULT = 4;   // pipeline depth, legal 2..8
  localparam int WIDTH_DEFAULT   = 32;  // payload bits per stage
  localparam int CNTW_DEFAULT    = 16;  // performance counter width

endpackage : pipe_stage_chain_pkg

// File: rtl/pipe_stage_chain_if.sv
// Bus bundle for pipe_stage_chain.
// master : the producer/observer side (drives payload, stall, flush, halt).
// slave  : the pipeline side (drives ready, tail payload, stage view,
//          performance counters and the registered halt flag).
// Signals:
//   iInValid/iInData/oInReady    head handshake
//   iStall/iFlush [NSTAGES]      per-stage hold and kill requests
//   iHalt / oHalted              freeze request and its one-cycle-late copy
//   oOutValid/oOutData           tail retire
//   oStageValid/oStageData       per-stage view, stage k at [k*WIDTH +: WIDTH]
//   oStallCount/oBubbleCount     saturating performance counters

interface pipe_stage_chain_if
  import pipe_stage_chain_pkg::*;
#(
  parameter int NSTAGES = NSTAGES_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int CNTW    = CNTW_DEFAULT
);

  logic                       iInValid;
  logic [WIDTH-1:0]           iInData;
  logic                       oInReady;
  logic [NSTAGES-1:0]         iStall;
  logic [NSTAGES-1:0]         iFlush;
  logic                       iHalt;
  logic                       oOutValid;
  logic [WIDTH-1:0]           oOutData;
  logic [NSTAGES-1:0]         oStageValid;
  logic [NSTAGES*WIDTH-1:0]   oStageData;
  logic [CNTW-1:0]            oStallCount;
  logic [CNTW-1:0]            oBubbleCount;
  logic                       oHalted;

  modport master (
    output iInValid, iInData, iStall, iFlush, iHalt,
    input  oInReady, oOutValid, oOutData, oStageValid, oStageData,
           oStallCount, oBubbleCount, oHalted
  );

  modport slave (
    input  iInValid, iInData, iStall, iFlush, iHalt,
    output oInReady, oOutValid, oOutData, oStageValid, oStageData,
           oStallCount, oBubbleCount, oHalted
  );

endinterface : pipe_stage_chain_if

// File: rtl/pipe_stage_chain_stage.sv
// pipe_stage: one valid+data pipeline register.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   hold              keep current content (valid may still be flushed)
//   flush             kill the current content of this stage
//   load_valid/data   what enters the stage when it is not held
//   valid/data        registered stage content

module pipe_stage
  import pipe_stage_chain_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // NOTE: data is reset as well as valid so the stage view reads all-zero
  // straight out of reset; it is a single register, not a memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (hold) begin
      // Flush beats hold: a held stage may still lose its content.
      // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
      valid <= valid & ~flush;
    end else begin
      // Leaving content moves on regardless of flush; the flush of this
      // stage is applied by the downstream stage's load_valid.
      valid <= load_valid;
      data  <= load_data;
    end
  end

endmodule : pipe_stage

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: NSTAGES-deep in-order pipeline with per-stage stall,
// per-stage flush, global halt and saturating stall/bubble counters.
// Ports:
//   iCLK, iRST   clock, asynchronous active-high reset
//   bus          pipe_stage_chain_if.slave (handshake, controls, stage view,
//                counters, registered halt)

module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int NSTAGES = NSTAGES_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int CNTW    = CNTW_DEFAULT
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  pipe_stage_chain_if.slave    bus
);

  logic [NSTAGES-1:0] hold;
  logic [NSTAGES-1:0] valid;
  logic [NSTAGES-1:0] load_valid;
  logic [WIDTH-1:0]   data      [NSTAGES];
  logic [WIDTH-1:0]   load_data [NSTAGES];
  logic [CNTW-1:0]    stall_cnt;
  logic [CNTW-1:0]    bubble_cnt;
  logic               halted;

  // Hold ripples from the tail toward the head, but only through stages
  // that hold something: an empty stage absorbs backpressure. The running
  // variable keeps the chain free of a combinational self-reference.
  always_comb begin : hold_chain
    logic h;
    // NOTE: default assignment first so no latch is inferred.
    hold = '0;
    h = bus.iHalt | bus.iStall[NSTAGES-1];
    hold[NSTAGES-1] = h;
    for (int k = NSTAGES - 2; k >= 0; k--) begin
      h = bus.iHalt | bus.iStall[k] | (h & valid[k]);
      hold[k] = h;
    end
  end

  // What each stage loads when not held. A held or flushed upstream stage
  // hands a bubble forward.
  always_comb begin : load_mux
    load_valid   = '0;
    load_data[0] = bus.iInData;
    load_valid[0] = bus.iInValid;
    for (int k = 1; k < NSTAGES; k++) begin
      load_valid[k] = valid[k-1] & ~bus.iFlush[k-1] & ~hold[k-1];
      load_data[k]  = data[k-1];
    end
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (iCLK),
      .rst        (iRST),
      .hold       (hold[k]),
      .flush      (bus.iFlush[k]),
      .load_valid (load_valid[k]),
      .load_data  (load_data[k]),
      .valid      (valid[k]),
      .data       (data[k])
    );
    assign bus.oStageData[k*WIDTH +: WIDTH] = data[k];
  end

  assign bus.oStageValid  = valid;
  assign bus.oInReady     = ~hold[0];
  assign bus.oOutValid    = valid[NSTAGES-1] & ~hold[NSTAGES-1] & ~bus.iFlush[NSTAGES-1];
  assign bus.oOutData     = data[NSTAGES-1];
  assign bus.oStallCount  = stall_cnt;
  assign bus.oBubbleCount = bubble_cnt;
  assign bus.oHalted      = halted;

  // Halt forces hold at the tail, so the bubble counter is naturally frozen
  // while halted; rejected head offers still count as stalls.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      halted     <= 1'b0;
    end else begin
      halted <= bus.iHalt;
      if (bus.iInValid && !hold[0] == 1'b0 && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNTW'(1);
      if (!valid[NSTAGES-1] && !hold[NSTAGES-1] && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNTW'(1);
    end
  end

endmodule : pipe_stage_chain
